// File: rtl/fht_input_loader.sv
// FHT input loader: streams one N-sample frame into the four FHT banks, then hands it to the stage controller.
// Build option FHT_LOADER_BITREV_EN selects bit-reversed bank/address mapping; natural order when undefined.
module fht_input_loader #(
  parameter int A_BIT = 8,
  parameter int N_BIT = 10,   // must equal A_BIT + 2
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  input  logic             iLAST,
  output logic             oREADY,
  input  logic             iFHT_RDY,
  output logic             oSTART,
  output logic [D_BIT-1:0] oDATA,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic             oDONE,
  output logic             oERR,
  output logic [7:0]       oFRAME_CNT
);

  typedef enum logic [1:0] {LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [N_BIT-1:0] LP_CNT_LAST  = '1;
  localparam logic [2:0]       LP_RETRY_AT  = 3'd4;
  localparam logic [2:0]       LP_WAIT_SAT  = 3'd5;

  state_t           r_state, w_state_nxt;
  logic [N_BIT-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_wait, w_wait_nxt;
  logic             r_start, w_start_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [7:0]       r_fcnt, w_fcnt_nxt;
  logic [D_BIT-1:0] r_data;
  logic [A_BIT-1:0] r_addr;
  logic [3:0]       r_we;
  logic             w_accept;
  logic [N_BIT-1:0] w_map;

  assign oREADY   = (r_state == LOAD) & iFHT_RDY;
  assign w_accept = iVALID & oREADY;

`ifdef FHT_LOADER_BITREV_EN
  always_comb begin
    for (int i = 0; i < N_BIT; i++) w_map[i] = r_cnt[N_BIT-1-i];
  end
`else
  assign w_map = r_cnt;
`endif

  // Next-state logic; the start/done/error pulses are computed here and registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = r_wait;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_fcnt_nxt  = r_fcnt;
    unique case (r_state)
      LOAD: begin
        if (w_accept) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = START;
          end else if (iLAST) begin
            w_cnt_nxt = '0;
            w_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      START: begin
        w_start_nxt = 1'b1;
        w_wait_nxt  = '0;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A controller that misses the first pulse gets exactly one more; the counter then saturates.
        if (!iFHT_RDY) begin
          w_state_nxt = WAIT_DONE;
        end else begin
          if (r_wait == LP_RETRY_AT) w_start_nxt = 1'b1;
          if (r_wait != LP_WAIT_SAT) w_wait_nxt = r_wait + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (iFHT_RDY) begin
          w_done_nxt  = 1'b1;
          w_fcnt_nxt  = r_fcnt + 8'd1;
          w_state_nxt = LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wait  <= w_wait_nxt;
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_data <= '0;
      r_addr <= '0;
      r_we   <= '0;
    end else begin
      r_we <= w_accept ? (4'b0001 << w_map[1:0]) : 4'b0000;
      if (w_accept) begin
        r_data <= iDATA;
        r_addr <= w_map[N_BIT-1:2];
      end
    end
  end

  assign oSTART     = r_start;
  assign oDONE      = r_done;
  assign oERR       = r_err;
  assign oFRAME_CNT = r_fcnt;
  assign oDATA      = r_data;
  assign oADDR_WR   = r_addr;
  assign oWE        = r_we;

endmodule

// File: tb/tb_fht_input_loader.sv
// Scoreboard bench for fht_input_loader: stimulus pushes expected bank writes, a monitor pops and compares them.
// Expected mapping follows FHT_LOADER_BITREV_EN the same way the design build does.
module tb_fht_input_loader;

  logic        iCLK;
  logic        iRESET;
  logic [15:0] iDATA;
  logic        iVALID;
  logic        iLAST;
  logic        oREADY;
  logic        fhtRdy;
  logic        oSTART;
  logic [15:0] oDATA;
  logic [7:0]  oADDR_WR;
  logic [3:0]  oWE;
  logic        oDONE;
  logic        oERR;
  logic [7:0]  oFRAME_CNT;

  logic        ctrlRdy;
  logic        forceBusy;
  int          ctrlMode;

  int          checks;
  int          errors;
  int          cyc;
  int          expIdx;
  int          lastAcceptCycle;
  int          lastStartCycle;
  int          prevStartCycle;
  int          doneCycle;
  int          weCount;
  int          startCount;
  int          errCount;
  int          doneCount;
  logic [25:0] expQ[$];
  logic [15:0] mem [4][256];

  assign fhtRdy = ctrlRdy & ~forceBusy;

  fht_input_loader dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iDATA      (iDATA),
    .iVALID     (iVALID),
    .iLAST      (iLAST),
    .oREADY     (oREADY),
    .iFHT_RDY   (fhtRdy),
    .oSTART     (oSTART),
    .oDATA      (oDATA),
    .oADDR_WR   (oADDR_WR),
    .oWE        (oWE),
    .oDONE      (oDONE),
    .oERR       (oERR),
    .oFRAME_CNT (oFRAME_CNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic logic [9:0] mapIdx(input int idx);
    logic [9:0] v;
    logic [9:0] r;
    v = idx[9:0];
`ifdef FHT_LOADER_BITREV_EN
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no event, expected one within the cycle budget", name);
  endtask

  // Drive one sample (after optional idle gaps), wait for the handshake and record the expected write.
  task automatic applyStimulus(input logic [15:0] d, input logic last, input int gapPct);
    int waitCnt;
    logic [9:0] m;
    waitCnt = 0;
    while (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
      @(posedge iCLK); #1;
    end
    iDATA  = d;
    iLAST  = last;
    iVALID = 1'b1;
    forever begin
      @(negedge iCLK);
      if (oREADY) break;
      waitCnt++;
      if (waitCnt > 5000) break;
    end
    if (waitCnt > 5000) begin
      failTimeout("accept");
      @(posedge iCLK); #1;
      iVALID = 1'b0;
      iLAST  = 1'b0;
      return;
    end
    lastAcceptCycle = cyc;
    @(posedge iCLK); #1;
    iVALID = 1'b0;
    iLAST  = 1'b0;
    m = mapIdx(expIdx);
    expQ.push_back({m[1:0], m[9:2], d});
    expIdx = (last || expIdx == 1023) ? 0 : expIdx + 1;
  endtask

  task automatic runMonitor();
    logic [25:0] e;
    logic [1:0]  b;
    forever begin
      @(negedge iCLK);
      if (!iRESET) begin
        if (oWE != 4'b0000) begin
          weCount++;
          b = oWE[3] ? 2'd3 : oWE[2] ? 2'd2 : oWE[1] ? 2'd1 : 2'd0;
          checkOutput("we_onehot", 32'($countones(oWE)), 32'd1);
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL write_unexpected: got bank %0d addr %0d data %0h, expected no write", b, oADDR_WR, oDATA);
          end else begin
            e = expQ.pop_front();
            checkOutput("write", {6'b0, b, oADDR_WR, oDATA}, {6'b0, e});
          end
          mem[b][oADDR_WR] = oDATA;
        end
        if (oSTART) begin
          startCount++;
          prevStartCycle = lastStartCycle;
          lastStartCycle = cyc;
        end
        if (oERR) errCount++;
        if (oDONE) begin
          doneCount++;
          doneCycle = cyc;
        end
      end
    end
  endtask

  // Controller model: takes the start 2 cycles after the pulse and stays busy for 2620 cycles.
  task automatic runController();
    forever begin
      @(negedge iCLK);
      if (ctrlMode == 1 && oSTART && !iRESET) begin
        @(posedge iCLK);
        @(posedge iCLK);
        #1 ctrlRdy = 1'b0;
        repeat (2620) @(posedge iCLK);
        #1 ctrlRdy = 1'b1;
      end
    end
  endtask

  task automatic waitStart(input int base, input int limit);
    int n;
    n = 0;
    while (startCount == base && n < limit) begin
      @(negedge iCLK);
      n++;
    end
    if (startCount == base) failTimeout("start");
  endtask

  // Full frame already sent: check start timing, busy hold-off, done pulse and frame count.
  task automatic runHandoff(input logic [7:0] expFrames);
    int baseStart;
    int baseDone;
    int n;
    int readyHigh;
    baseStart = startCount;
    baseDone  = doneCount;
    waitStart(baseStart, 20);
    checkOutput("start_latency", 32'(lastStartCycle - lastAcceptCycle), 32'd2);
    n = 0;
    readyHigh = 0;
    do begin
      @(negedge iCLK);
      n++;
      if (oDONE) break;
      if (oREADY) readyHigh++;
    end while (n < 4000);
    checkOutput("done_seen", {31'b0, oDONE}, 32'd1);
    checkOutput("ready_low_busy", 32'(readyHigh), 32'd0);
    repeat (3) @(negedge iCLK);
    checkOutput("done_pulses", 32'(doneCount - baseDone), 32'd1);
    checkOutput("done_latency", 32'(doneCycle - lastStartCycle), 32'd2623);
    checkOutput("start_pulses", 32'(startCount - baseStart), 32'd1);
    checkOutput("frame_cnt", {24'b0, oFRAME_CNT}, {24'b0, expFrames});
    checkOutput("ready_after_done", {31'b0, oREADY}, 32'd1);
    @(posedge iCLK); #1;
  endtask

  initial begin
    int baseWe;
    int baseStart;
    int baseErr;
    int bad;
    logic [9:0] m;
    checks = 0; errors = 0; expIdx = 0;
    weCount = 0; startCount = 0; errCount = 0; doneCount = 0;
    lastAcceptCycle = 0; lastStartCycle = 0; prevStartCycle = 0; doneCycle = 0;
    iRESET = 1'b1; iDATA = '0; iVALID = 1'b0; iLAST = 1'b0;
    ctrlRdy = 1'b1; forceBusy = 1'b0; ctrlMode = 1;
    for (int b = 0; b < 4; b++) for (int a = 0; a < 256; a++) mem[b][a] = 16'hDEAD;
    fork
      runMonitor();
      runController();
    join_none

    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("rst_start", {31'b0, oSTART}, 32'd0);
    checkOutput("rst_we", {28'b0, oWE}, 32'd0);
    checkOutput("rst_done", {31'b0, oDONE}, 32'd0);
    checkOutput("rst_err", {31'b0, oERR}, 32'd0);
    checkOutput("rst_data", {16'b0, oDATA}, 32'd0);
    checkOutput("rst_addr", {24'b0, oADDR_WR}, 32'd0);
    checkOutput("rst_frame_cnt", {24'b0, oFRAME_CNT}, 32'd0);
    @(posedge iCLK); #1 iRESET = 1'b0;
    @(negedge iCLK);
    checkOutput("ready_after_reset", {31'b0, oREADY}, 32'd1);
    @(posedge iCLK); #1;

    // Back-to-back frame with a cooperative controller.
    baseWe = weCount;
    for (int i = 0; i < 1024; i++) applyStimulus(16'(i), 1'b0, 0);
    runHandoff(8'd1);
    checkOutput("we_count_b2b", 32'(weCount - baseWe), 32'd1024);
`ifdef FHT_LOADER_BITREV_EN
    checkOutput("s1_b0_a128", {16'b0, mem[0][128]}, 32'd1);
    checkOutput("s2_b0_a64", {16'b0, mem[0][64]}, 32'd2);
    checkOutput("s3_b0_a192", {16'b0, mem[0][192]}, 32'd3);
    checkOutput("s512_b1_a0", {16'b0, mem[1][0]}, 32'd512);
`else
    checkOutput("s1_b1_a0", {16'b0, mem[1][0]}, 32'd1);
    checkOutput("s2_b2_a0", {16'b0, mem[2][0]}, 32'd2);
    checkOutput("s4_b0_a1", {16'b0, mem[0][1]}, 32'd4);
    checkOutput("s5_b1_a1", {16'b0, mem[1][1]}, 32'd5);
`endif
    checkOutput("s1023_b3_a255", {16'b0, mem[3][255]}, 32'd1023);

    // Same frame with random valid gaps; bank contents must match sample index.
    for (int b = 0; b < 4; b++) for (int a = 0; a < 256; a++) mem[b][a] = 16'hDEAD;
    baseWe = weCount;
    for (int i = 0; i < 1024; i++) applyStimulus(16'(i), 1'b0, 50);
    runHandoff(8'd2);
    checkOutput("we_count_gaps", 32'(weCount - baseWe), 32'd1024);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      m = mapIdx(i);
      if (mem[m[1:0]][m[9:2]] !== 16'(i)) bad++;
    end
    checkOutput("bank_contents", 32'(bad), 32'd0);

    // Short frame ended by iLAST on sample 99, then a clean frame to a controller that ignores start.
    ctrlMode = 0;
    baseWe = weCount; baseStart = startCount; baseErr = errCount;
    for (int i = 0; i < 100; i++) applyStimulus(16'(i), i == 99, 0);
    repeat (5) @(negedge iCLK);
    checkOutput("err_pulses", 32'(errCount - baseErr), 32'd1);
    checkOutput("we_count_short", 32'(weCount - baseWe), 32'd100);
    checkOutput("no_start_short", 32'(startCount - baseStart), 32'd0);
    @(posedge iCLK); #1;
    for (int i = 0; i < 1024; i++) applyStimulus(16'(i), 1'b0, 0);
    waitStart(baseStart, 20);
    repeat (20) @(negedge iCLK);
    checkOutput("start_retry_pulses", 32'(startCount - baseStart), 32'd2);
    checkOutput("start_retry_gap", 32'(lastStartCycle - prevStartCycle), 32'd5);
    checkOutput("frame_cnt_held", {24'b0, oFRAME_CNT}, 32'd2);

    // Recover via reset, then a partial frame with a controller stall while loading.
    @(posedge iCLK); #1 iRESET = 1'b1;
    repeat (2) @(posedge iCLK);
    #1 iRESET = 1'b0;
    expQ.delete();
    expIdx = 0;
    @(negedge iCLK);
    checkOutput("frame_cnt_reset", {24'b0, oFRAME_CNT}, 32'd0);
    checkOutput("ready_reset", {31'b0, oREADY}, 32'd1);
    @(posedge iCLK); #1;
    for (int i = 0; i < 300; i++) applyStimulus(16'(i), 1'b0, 0);
    forceBusy = 1'b1;
    iDATA = 16'h5555;
    iVALID = 1'b1;
    @(negedge iCLK);
    checkOutput("ready_stalled", {31'b0, oREADY}, 32'd0);
    @(negedge iCLK);
    @(negedge iCLK);
    baseWe = weCount;
    repeat (4) @(negedge iCLK);
    @(posedge iCLK); #1;
    iVALID = 1'b0;
    forceBusy = 1'b0;
    @(negedge iCLK);
    checkOutput("no_write_stalled", 32'(weCount - baseWe), 32'd0);
    @(posedge iCLK); #1;
    for (int i = 300; i < 500; i++) applyStimulus(16'(i), 1'b0, 0);
    checkOutput("we_before_reset", {31'b0, oWE != 4'b0000}, 32'd1);
    #2 iRESET = 1'b1;
    #1;
    checkOutput("async_we", {28'b0, oWE}, 32'd0);
    checkOutput("async_data", {16'b0, oDATA}, 32'd0);
    checkOutput("async_addr", {24'b0, oADDR_WR}, 32'd0);
    checkOutput("async_ready", {31'b0, oREADY}, 32'd1);
    expQ.delete();
    expIdx = 0;
    @(posedge iCLK); #1 iRESET = 1'b0;
    mem[0][0] = 16'h0000;
    @(posedge iCLK); #1;
    applyStimulus(16'hABCD, 1'b0, 0);
    @(negedge iCLK);
    @(negedge iCLK);
    checkOutput("first_after_reset", {16'b0, mem[0][0]}, 32'h0000ABCD);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fht_input_loader.md
Name: fht_input_loader

Overview:
- Upstream neighbour of the FHT stage controller.
- Accepts a serial stream of N real samples over a valid/ready handshake and writes them into the 4 FHT RAM banks, bank A, in bit-reversed order so that stage 0 can read in natural order.
- Pulses the controller's start input once a full frame is stored, then holds off new input until the controller reports ready again.

Parameters:
- A_BIT, 8, bank address width (256 words per bank)
- N_BIT, 10, log2 of frame length N (N = 4 * 2^A_BIT = 1024); N_BIT = A_BIT + 2 is required
- D_BIT, 16, sample width

Ports:
- iCLK  in  1  clock
- iRESET  in  1  asynchronous, active-high reset
- iDATA  in  D_BIT  input sample
- iVALID  in  1  sample valid
- iLAST  in  1  marks the final sample of a frame; qualified by iVALID
- oREADY  out  1  loader can accept a sample this cycle
- iFHT_RDY  in  1  controller ready (high = idle/finished)
- oSTART  out  1  one-cycle start pulse to the controller
- oDATA  out  D_BIT  write data to banks
- oADDR_WR  out  A_BIT  write address, common to all banks
- oWE  out  4  one-hot bank write enable, bit k = bank k
- oDONE  out  1  one-cycle pulse when the controller finishes the frame
- oERR  out  1  one-cycle pulse on a frame-length error
- oFRAME_CNT  out  8  frames completed, wraps 255 -> 0

Behaviour:
- Reset (iRESET high, asynchronous): state = LOAD, sample count = 0, oFRAME_CNT = 0. oSTART, oWE, oDONE and oERR are 0. oDATA and oADDR_WR are 0.
- Accept condition: iVALID & oREADY. oREADY = (state == LOAD) & iFHT_RDY; it is combinational from the state register and iFHT_RDY.
- Index mapping: idx = sample count (N_BIT bits); rev = bit-reverse of idx over N_BIT bits. Bank = rev[1:0], address = rev[N_BIT-1:2].
- Write pipeline: outputs are registered, so oDATA, oADDR_WR and oWE appear 1 cycle after the accept. oWE is 0 in every cycle that did not follow an accept.
- FSM states:
  - LOAD: accept samples; the count increments on each accept.
    - Accept with count == N-1 -> count = 0, go to START. iLAST is a don't-care on this sample.
    - Accept with iLAST = 1 and count != N-1 -> the sample is still written, then count = 0, oERR pulses next cycle, and the state stays in LOAD. The partial frame is discarded; no start is issued.
  - START: oSTART = 1 for exactly this one cycle (registered). The cycle before, the final bank write completed. Next state is WAIT_BUSY.
  - WAIT_BUSY: wait for iFHT_RDY = 0 (controller accepted the start), then go to WAIT_DONE. If iFHT_RDY is still 1 after 4 cycles, re-pulse oSTART once and keep waiting.
  - WAIT_DONE: on iFHT_RDY = 1 -> oDONE pulses 1 cycle, oFRAME_CNT increments, go to LOAD.
- iFHT_RDY falling while in LOAD (controller started by another master): oREADY drops and the count is held. Loading resumes when iFHT_RDY returns high.
- iVALID while oREADY = 0: ignored, no write. The sender must hold the sample.
- Reset mid-frame or mid-transform: all state is cleared immediately. The partially written bank content is not cleared.
- No arithmetic on data; oDATA = iDATA registered unchanged.

Optional Feature:
- Macro FHT_LOADER_BITREV_EN.
  - Defined: bit-reversed mapping as above.
  - Undefined: natural order, bank = idx[1:0], address = idx[N_BIT-1:2]. Use this for an upstream source that already delivers bit-reversed data. All other behaviour is unchanged.

Test Plan:
- Reset, then 1024 back-to-back valid samples with data = idx, iFHT_RDY = 1 -> sample 1 is written to bank 0 address 128 (rev = 512). Sample 2 is written to bank 0 address 64. Sample 3 is written to bank 0 address 192. Sample 512 is written to bank 1 address 0. oSTART pulses once, 2 cycles after the 1024th accept.
- Random iVALID gaps (50%) -> same bank contents as the back-to-back case; exactly 1024 oWE pulses; exactly one oSTART.
- iLAST asserted on sample 99 -> 100 writes occur and oERR pulses once. No oSTART. The next 1024 samples form a clean frame starting at count 0.
- Controller model lowers iFHT_RDY 2 cycles after oSTART and raises it 2620 cycles later -> oREADY stays 0 throughout. oDONE pulses 1 cycle and oFRAME_CNT goes 0 -> 1. oREADY returns to 1.
- Controller ignores the first start (iFHT_RDY stays 1) -> oSTART re-pulses exactly once, 5 cycles after the first pulse.
- iRESET asserted after 500 samples -> outputs clear asynchronously. The next frame's first write goes to bank 0 address 0.
- Built without FHT_LOADER_BITREV_EN -> sample 5 goes to bank 1 address 1.
